// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_pkg
// Purpose  : Shared mode encoding and prescaler divider helper for led_blink_array.
// Revision : 1.0
// ============================================================================
package led_blink_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_ONESHOT = 2'd3
    } led_mode_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        if (tick_hz == 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
// Module   : led_channel
// Purpose  : One LED channel: mode, half-period, tick counter, led and done regs.
// Revision : 1.0
// ============================================================================
module led_channel
    import led_blink_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reest,
    input  logic             tick,
    input  logic             we,
    input  logic [1:0]       mode,
    input  logic [PER_W-1:0] half_period,
    output logic             led,
    output logic             done
);

    led_mode_t        r_mode;
    led_mode_t        w_mode_nxt;
    led_mode_t        w_wr_mode;
    logic [PER_W-1:0] r_half;
    logic [PER_W-1:0] w_half_nxt;
    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] w_cnt_nxt;
    logic [PER_W-1:0] w_last;
    logic             w_term;
    logic             r_led;
    logic             w_led_nxt;
    logic             r_done;
    logic             w_done_nxt;

    assign w_wr_mode = led_mode_t'(mode);
    // A programmed half-period of 0 behaves like 1, so the terminal count is 0 either way.
    assign w_last    = (r_half == '0) ? '0 : (r_half - PER_W'(1));
    assign w_term    = (r_cnt == w_last);

    always_comb begin
        w_mode_nxt = r_mode;
        w_half_nxt = r_half;
        w_cnt_nxt  = r_cnt;
        w_led_nxt  = r_led;
        w_done_nxt = 1'b0;
        if (we) begin
            w_mode_nxt = w_wr_mode;
            w_half_nxt = half_period;
            w_cnt_nxt  = '0;
            w_led_nxt  = (w_wr_mode != LED_OFF);
        end else if (tick) begin
            case (r_mode)
                LED_BLINK: begin
                    if (w_term) begin
                        w_cnt_nxt = '0;
                        w_led_nxt = ~r_led;
                    end else begin
                        w_cnt_nxt = r_cnt + PER_W'(1);
                    end
                end
                LED_ONESHOT: begin
                    if (w_term) begin
                        w_cnt_nxt  = '0;
                        w_led_nxt  = 1'b0;
                        w_mode_nxt = LED_OFF;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + PER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reest) begin
        if (!reest) begin
            r_mode <= LED_OFF;
            r_half <= PER_W'(1);
            r_cnt  <= '0;
            r_led  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_half <= w_half_nxt;
            r_cnt  <= w_cnt_nxt;
            r_led  <= w_led_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign led  = r_led;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/led_blink_array.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_array
// Purpose  : Multi-channel LED driver: shared tick prescaler plus per-channel write decode.
// Revision : 1.0
// ============================================================================
module led_blink_array
    import led_blink_pkg::*;
#(
    parameter int NUM_LEDS = 3,
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int PER_W    = 16
) (
    input  logic                                            clk,
    input  logic                                            reest,
    input  logic                                            cfg_we,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                      cfg_mode,
    input  logic [PER_W-1:0]                                cfg_half_period,
    output logic [NUM_LEDS-1:0]                             led,
    output logic [NUM_LEDS-1:0]                             oneshot_done,
    output logic                                            tick
);

    localparam int unsigned C_DIV  = calc_div(CLK_HZ, TICK_HZ);
    localparam int          C_CH_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int          C_PC_W = (C_DIV > 2) ? $clog2(C_DIV) : 1;

    if (C_DIV < 2) begin : g_div_check
        $error("led_blink_array: CLK_HZ/TICK_HZ must be at least 2");
    end

    if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_num_check
        $error("led_blink_array: NUM_LEDS must be in 1..16");
    end

    logic [C_PC_W-1:0] r_pcnt;
    logic              r_tick;

    always_ff @(posedge clk or negedge reest) begin
        if (!reest) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else if (r_pcnt == C_PC_W'(C_DIV - 1)) begin
            r_pcnt <= '0;
            r_tick <= 1'b1;
        end else begin
            r_pcnt <= r_pcnt + C_PC_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

    // Channel numbers at or above NUM_LEDS match no instance, so those writes fall away.
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        logic w_we;
        assign w_we = cfg_we && (cfg_ch == C_CH_W'(gi));

        led_channel #(
            .PER_W (PER_W)
        ) u_channel (
            .clk         (clk),
            .reest       (reest),
            .tick        (r_tick),
            .we          (w_we),
            .mode        (cfg_mode),
            .half_period (cfg_half_period),
            .led         (led[gi]),
            .done        (oneshot_done[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_blink_array
// Purpose  : Directed self-checking bench for led_blink_array (3 channels, DIV=10).
// Revision : 1.0
// ============================================================================
module tb_led_blink_array;

    logic       clk;
    logic       reest;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_half_period;
    logic [2:0] led;
    logic [2:0] oneshot_done;
    logic       tick;

    int checks;
    int errors;

    led_blink_array #(
        .NUM_LEDS (3),
        .CLK_HZ   (10),
        .TICK_HZ  (1),
        .PER_W    (8)
    ) dut (
        .clk             (clk),
        .reest           (reest),
        .cfg_we          (cfg_we),
        .cfg_ch          (cfg_ch),
        .cfg_mode        (cfg_mode),
        .cfg_half_period (cfg_half_period),
        .led             (led),
        .oneshot_done    (oneshot_done),
        .tick            (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] hp);
        cfg_we          = 1'b1;
        cfg_ch          = ch;
        cfg_mode        = mode;
        cfg_half_period = hp;
        step();
        cfg_we          = 1'b0;
    endtask

    // Leaves the bench in the cycle where tick is high (prescaler just wrapped).
    task automatic wait_tick();
        int n;
        n = 0;
        step();
        while (tick !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: tick=%b required 1 within 30 cycles", tick);
        end
    endtask

    task automatic test_reset();
        reest = 1'b0;
        repeat (2) step();
        checks++;
        if (led !== 3'b000) begin errors++; $display("FAIL reset_led: got %b required 000", led); end
        checks++;
        if (oneshot_done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b required 000", oneshot_done); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b required 0", tick); end
        reest = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) begin
                checks++;
                if (tick !== 1'b0) begin errors++; $display("FAIL reset_first_tick_early: got %b required 0 after edge 9", tick); end
            end
            if (k == 10) begin
                checks++;
                if (tick !== 1'b1) begin errors++; $display("FAIL reset_first_tick: got %b required 1 after edge 10", tick); end
            end
        end
    endtask

    task automatic test_blink();
        int   n;
        logic e;
        wait_tick();
        step();
        write_cfg(2'd0, 2'd2, 8'd2);
        checks++;
        if (led[0] !== 1'b1) begin errors++; $display("FAIL blink_write: led0=%b required 1", led[0]); end
        for (int s = 1; s <= 60; s++) begin
            step();
            n = (s >= 19) ? ((s - 19) / 20 + 1) : 0;
            e = ~n[0];
            checks++;
            if (led[0] !== e) begin errors++; $display("FAIL blink_toggle s=%0d: led0=%b required %b", s, led[0], e); end
        end
    endtask

    task automatic test_oneshot();
        logic el;
        logic ed;
        wait_tick();
        step();
        write_cfg(2'd2, 2'd3, 8'd3);
        checks++;
        if (led[2] !== 1'b1) begin errors++; $display("FAIL oneshot_write: led2=%b required 1", led[2]); end
        for (int s = 1; s <= 50; s++) begin
            step();
            el = (s < 29);
            ed = (s == 29);
            checks++;
            if (led[2] !== el) begin errors++; $display("FAIL oneshot_led s=%0d: led2=%b required %b", s, led[2], el); end
            checks++;
            if (oneshot_done[2] !== ed) begin errors++; $display("FAIL oneshot_done s=%0d: done2=%b required %b", s, oneshot_done[2], ed); end
        end
    endtask

    task automatic test_collision();
        wait_tick();
        step();
        write_cfg(2'd0, 2'd2, 8'd1);
        repeat (8) step();
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL collision_align: tick=%b required 1", tick); end
        write_cfg(2'd1, 2'd2, 8'd1);
        checks++;
        if (led[1] !== 1'b1) begin errors++; $display("FAIL collision_write_wins: led1=%b required 1", led[1]); end
        checks++;
        if (led[0] !== 1'b0) begin errors++; $display("FAIL collision_other_ch: led0=%b required 0", led[0]); end
        repeat (9) step();
        checks++;
        if (led[1] !== 1'b1) begin errors++; $display("FAIL collision_hold: led1=%b required 1", led[1]); end
        step();
        checks++;
        if (led[1] !== 1'b0) begin errors++; $display("FAIL collision_next_tick: led1=%b required 0", led[1]); end
        checks++;
        if (led[0] !== 1'b1) begin errors++; $display("FAIL collision_ch0_next: led0=%b required 1", led[0]); end
    endtask

    task automatic test_boundaries();
        int   n;
        logic e;
        wait_tick();
        step();
        write_cfg(2'd0, 2'd0, 8'd1);
        write_cfg(2'd1, 2'd0, 8'd1);
        write_cfg(2'd2, 2'd0, 8'd1);
        checks++;
        if (led !== 3'b000) begin errors++; $display("FAIL bound_all_off: led=%b required 000", led); end
        write_cfg(2'd3, 2'd1, 8'd5);
        checks++;
        if (led !== 3'b000) begin errors++; $display("FAIL bound_ch3_led: led=%b required 000", led); end
        for (int s = 1; s <= 20; s++) begin
            step();
            checks++;
            if (led !== 3'b000 || oneshot_done !== 3'b000) begin
                errors++;
                $display("FAIL bound_ch3_hold s=%0d: led=%b done=%b required 000/000", s, led, oneshot_done);
            end
        end
        wait_tick();
        step();
        write_cfg(2'd1, 2'd2, 8'd0);
        checks++;
        if (led !== 3'b010) begin errors++; $display("FAIL h0_write: led=%b required 010", led); end
        for (int s = 1; s <= 30; s++) begin
            step();
            n = (s >= 9) ? ((s - 9) / 10 + 1) : 0;
            e = ~n[0];
            checks++;
            if (led !== {1'b0, e, 1'b0}) begin errors++; $display("FAIL h0_toggle s=%0d: led=%b required %b", s, led, {1'b0, e, 1'b0}); end
        end
    endtask

    task automatic test_independence();
        int         n;
        logic [2:0] e;
        wait_tick();
        step();
        write_cfg(2'd0, 2'd2, 8'd1);
        write_cfg(2'd1, 2'd1, 8'd1);
        write_cfg(2'd2, 2'd0, 8'd1);
        for (int s = 1; s <= 100; s++) begin
            step();
            n = (s >= 7) ? ((s - 7) / 10 + 1) : 0;
            e = {1'b0, 1'b1, ~n[0]};
            checks++;
            if (led !== e || oneshot_done !== 3'b000) begin
                errors++;
                $display("FAIL indep s=%0d: led=%b done=%b required %b/000", s, led, oneshot_done, e);
            end
        end
    endtask

    task automatic test_reset_midblink();
        step();
        #3;
        reest = 1'b0;
        #1;
        checks++;
        if (led !== 3'b000) begin errors++; $display("FAIL async_reset_led: got %b required 000", led); end
        checks++;
        if (oneshot_done !== 3'b000) begin errors++; $display("FAIL async_reset_done: got %b required 000", oneshot_done); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL async_reset_tick: got %b required 0", tick); end
        repeat (3) step();
        reest = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) begin
                checks++;
                if (tick !== 1'b0) begin errors++; $display("FAIL rerelease_tick_early: got %b required 0", tick); end
            end
            if (k == 10) begin
                checks++;
                if (tick !== 1'b1) begin errors++; $display("FAIL rerelease_first_tick: got %b required 1", tick); end
                checks++;
                if (led !== 3'b000) begin errors++; $display("FAIL rerelease_led: got %b required 000", led); end
            end
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reest           = 1'b0;
        cfg_we          = 1'b0;
        cfg_ch          = 2'd0;
        cfg_mode        = 2'd0;
        cfg_half_period = 8'd0;
        test_reset();
        test_blink();
        test_oneshot();
        test_collision();
        test_boundaries();
        test_independence();
        test_reset_midblink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
